// File: rtl/apb_uart_ctrl.sv
// APB3 slave UART: register file, TX/RX FIFOs and full-duplex UART engines in the PCLK domain.
// Register map (word index PADDR[3:2]): DATA, STAT, CTRL, BAUD.
module apb_uart_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 20,
    parameter int DATA_BITS  = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [3:0]            PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  TXD,
    input  logic                  RXD,
    output logic                  IRQ
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                  w_xfer, w_wr, w_rd;
    logic [1:0]            w_addr;
    logic                  w_ctrl_wr, w_stat_wr;
    logic                  w_baud_ok;
    logic [DIV_WIDTH:0]    w_baud_p1;
    logic [DIV_WIDTH-1:0]  w_half_m1;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_bits;

    logic [4:0]            r_ctrl;
    logic [DIV_WIDTH-1:0]  r_baud;
    logic                  r_frame_err, r_overrun, r_irq;

    logic [DATA_BITS-1:0]  r_tx_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_tx_wp, r_tx_rp;
    logic [CW-1:0]         r_tx_cnt;
    logic                  w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_can, w_tx_tick;

    logic [DATA_BITS-1:0]  r_rx_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_rx_wp, r_rx_rp;
    logic [CW-1:0]         r_rx_cnt;
    logic                  w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;

    logic [1:0]            r_tx_state;
    logic [DIV_WIDTH-1:0]  r_tx_div;
    logic [BW-1:0]         r_tx_bit;
    logic [DATA_BITS-1:0]  r_tx_shift;
    logic                  r_txd;

    logic                  r_rx_s1, r_rx_s2, r_rx_prev;
    logic [1:0]            r_rx_state;
    logic [DIV_WIDTH-1:0]  r_rx_div;
    logic [BW-1:0]         r_rx_bit;
    logic [DATA_BITS-1:0]  r_rx_shift;
    logic                  w_rx_fall, w_rx_kill, w_rx_tick, w_rx_mid;
    logic                  w_rx_stop, w_rx_push_req, w_rx_ferr, w_rx_ovr;

    assign w_xfer    = PSEL & PENABLE;
    assign w_wr      = w_xfer & PWRITE;
    assign w_rd      = w_xfer & ~PWRITE;
    assign w_addr    = PADDR[3:2];
    assign w_ctrl_wr = w_wr & (w_addr == 2'd2);
    assign w_stat_wr = w_wr & (w_addr == 2'd1);
    assign w_baud_ok = r_baud >= DIV_WIDTH'(3);
    assign w_baud_p1 = {1'b0, r_baud} + (DIV_WIDTH+1)'(1);
    assign w_half_m1 = w_baud_p1[DIV_WIDTH:1] - DIV_WIDTH'(1);
    assign w_unused_bits = ^{PADDR[1:0], PWDATA, w_baud_p1[0]};

    assign w_tx_full  = r_tx_cnt == CW'(FIFO_DEPTH);
    assign w_tx_empty = r_tx_cnt == '0;
    assign w_rx_full  = r_rx_cnt == CW'(FIFO_DEPTH);
    assign w_rx_empty = r_rx_cnt == '0;

    assign w_tx_push = w_wr & (w_addr == 2'd0) & ~w_tx_full;
    assign w_rx_pop  = w_rd & (w_addr == 2'd0) & ~w_rx_empty;
    assign w_tx_can  = r_ctrl[0] & ~w_tx_empty & w_baud_ok;
    assign w_tx_tick = r_tx_div >= r_baud;
    assign w_tx_pop  = w_tx_can & ((r_tx_state == S_IDLE) | ((r_tx_state == S_STOP) & w_tx_tick));

    // Clearing rx_en takes effect on the very edge of the CTRL write.
    assign w_rx_kill     = ~r_ctrl[1] | (w_ctrl_wr & ~PWDATA[1]);
    assign w_rx_fall     = r_rx_prev & ~r_rx_s2;
    assign w_rx_tick     = r_rx_div >= r_baud;
    assign w_rx_mid      = r_rx_div >= w_half_m1;
    assign w_rx_stop     = (r_rx_state == S_STOP) & w_rx_tick & ~w_rx_kill;
    assign w_rx_push_req = w_rx_stop & r_rx_s2;
    assign w_rx_ferr     = w_rx_stop & ~r_rx_s2;
    assign w_rx_push     = w_rx_push_req & ~w_rx_full;
    assign w_rx_ovr      = w_rx_push_req & w_rx_full;

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            2'd0: if (!w_rx_empty) w_rdata[DATA_BITS-1:0] = r_rx_mem[r_rx_rp];
            2'd1: w_rdata[5:0] = {r_frame_err, r_overrun, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
            2'd2: w_rdata[4:0] = r_ctrl;
            default: w_rdata[DIV_WIDTH-1:0] = r_baud;
        endcase
    end

    assign PRDATA  = w_rd ? w_rdata : '0;
    assign PSLVERR = w_xfer & (w_addr == 2'd0) & (PWRITE ? w_tx_full : w_rx_empty);
    assign PREADY  = 1'b1;
    assign TXD     = r_txd;
    assign IRQ     = r_irq;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_ctrl      <= '0;
            r_baud      <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ctrl <= PWDATA[4:0];
            if (w_wr && w_addr == 2'd3) r_baud <= PWDATA[DIV_WIDTH-1:0];
            r_frame_err <= w_rx_ferr | (r_frame_err & ~(w_stat_wr & PWDATA[5]));
            r_overrun   <= w_rx_ovr  | (r_overrun   & ~(w_stat_wr & PWDATA[4]));
            r_irq <= (r_ctrl[2] & ~w_rx_empty) | (r_ctrl[3] & w_tx_empty) |
                     (r_ctrl[4] & (r_overrun | r_frame_err));
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= PWDATA[DATA_BITS-1:0];
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + CW'(1);
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - CW'(1);
            if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + CW'(1);
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - CW'(1);
        end
    end

    // TX engine: the FIFO head is popped on the edge a frame starts, including back-to-back starts from STOP.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_tx_state <= S_IDLE;
            r_tx_div   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    if (w_tx_can) begin
                        r_tx_state <= S_START;
                        r_tx_div   <= '0;
                        r_txd      <= 1'b0;
                        r_tx_shift <= r_tx_mem[r_tx_rp];
                    end
                end
                S_START: begin
                    if (w_tx_tick) begin
                        r_tx_state <= S_DATA;
                        r_tx_div   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                    end else begin
                        r_tx_div <= r_tx_div + DIV_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_div <= '0;
                        if (r_tx_bit == BW'(DATA_BITS - 1)) begin
                            r_tx_state <= S_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + BW'(1);
                            r_tx_shift <= r_tx_shift >> 1;
                            r_txd      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_div <= r_tx_div + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    if (w_tx_tick) begin
                        r_tx_div <= '0;
                        if (w_tx_can) begin
                            r_tx_state <= S_START;
                            r_txd      <= 1'b0;
                            r_tx_shift <= r_tx_mem[r_tx_rp];
                        end else begin
                            r_tx_state <= S_IDLE;
                        end
                    end else begin
                        r_tx_div <= r_tx_div + DIV_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    // RX engine: start bit is re-checked at mid-bit to reject glitches, then every bit is sampled one period later.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_div   <= '0;
            r_rx_bit   <= '0;
        end else begin
            r_rx_s1   <= RXD;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (w_rx_kill) begin
                r_rx_state <= S_IDLE;
                r_rx_div   <= '0;
            end else begin
                case (r_rx_state)
                    S_IDLE: begin
                        if (w_rx_fall && w_baud_ok) begin
                            r_rx_state <= S_START;
                            r_rx_div   <= '0;
                        end
                    end
                    S_START: begin
                        if (w_rx_mid) begin
                            r_rx_div   <= '0;
                            r_rx_bit   <= '0;
                            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                        end else begin
                            r_rx_div <= r_rx_div + DIV_WIDTH'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_rx_tick) begin
                            r_rx_div   <= '0;
                            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                            if (r_rx_bit == BW'(DATA_BITS - 1)) r_rx_state <= S_STOP;
                            else                                r_rx_bit   <= r_rx_bit + BW'(1);
                        end else begin
                            r_rx_div <= r_rx_div + DIV_WIDTH'(1);
                        end
                    end
                    default: begin
                        if (w_rx_tick) begin
                            r_rx_div   <= '0;
                            r_rx_state <= S_IDLE;
                        end else begin
                            r_rx_div <= r_rx_div + DIV_WIDTH'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
